// File: rtl/trap_csr_unit_pkg.sv
// rtl/trap_csr_unit_pkg.sv - shared types and constants for the trap/CSR unit
package trap_csr_unit_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csrOp_e;

  typedef enum logic {
    REDIRECT_IDLE    = 1'b0,
    REDIRECT_PENDING = 1'b1
  } redirectState_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;

  // MPP is hardwired to machine mode; only MIE and MPIE carry state.
  function automatic logic [31:0] packMstatus(input logic mie, input logic mpie);
    logic [31:0] value;
    value = '0;
    value[MSTATUS_MIE_BIT] = mie;
    value[MSTATUS_MPIE_BIT] = mpie;
    value[MSTATUS_MPP_LO +: 2] = 2'b11;
    return value;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free-running counter with per-half CSR write
module csr_counter64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        incEnable,
  input  logic        writeLo,
  input  logic        writeHi,
  input  logic [31:0] writeData,
  output logic [63:0] count
);

  // A write to either half suppresses the increment for the whole counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (writeLo || writeHi) begin
      count[31:0]  <= writeLo ? writeData : count[31:0];
      count[63:32] <= writeHi ? writeData : count[63:32];
    end else if (incEnable) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode CSR file, trap/mret sequencing and fetch redirect
module trap_csr_unit
  import trap_csr_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trapTaken,
  input  logic [3:0]  trapCause,
  input  logic [31:0] trapValue,
  input  logic [31:0] trapPC,
  input  logic        mretSignal,
  input  logic        retireValid,
  input  logic        csrValid,
  input  logic [1:0]  csrOp,
  input  logic [11:0] csrAddress,
  input  logic [31:0] csrWriteData,
  output logic [31:0] csrReadData,
  output logic        csrIllegal,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  input  logic        redirectReady,
  output logic        mstatusMIE
);

  logic        mie;
  logic        mpie;
  logic [29:0] mtvecBase;
  logic [31:0] mscratch;
  logic [29:0] mepcBase;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic        mapped;
  logic [31:0] oldValue;
  logic [31:0] newValue;
  logic        writeRequested;
  logic        csrWrite;
  logic        mretTaken;
  logic        redirectEvent;
  logic [31:0] redirectTarget;

  redirectState_e state;
  redirectState_e nextState;

  always_comb begin
    mapped   = 1'b1;
    oldValue = '0;
    case (csrAddress)
      CSR_MSTATUS:                oldValue = packMstatus(mie, mpie);
      CSR_MISA:                   oldValue = MISA_VALUE;
      CSR_MTVEC:                  oldValue = {mtvecBase, 2'b00};
      CSR_MSCRATCH:               oldValue = mscratch;
      CSR_MEPC:                   oldValue = {mepcBase, 2'b00};
      CSR_MCAUSE:                 oldValue = mcause;
      CSR_MTVAL:                  oldValue = mtval;
      CSR_MCYCLE, CSR_CYCLE:      oldValue = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:    oldValue = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  oldValue = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: oldValue = minstret[63:32];
      CSR_MHARTID:                oldValue = HART_ID;
      default:                    mapped = 1'b0;
    endcase
  end

  // Set/clear with a zero operand are pure reads and never count as writes.
  always_comb begin
    newValue       = oldValue;
    writeRequested = 1'b0;
    case (csrOp)
      CSR_RW: begin
        newValue       = csrWriteData;
        writeRequested = 1'b1;
      end
      CSR_RS: begin
        newValue       = oldValue | csrWriteData;
        writeRequested = |csrWriteData;
      end
      CSR_RC: begin
        newValue       = oldValue & ~csrWriteData;
        writeRequested = |csrWriteData;
      end
      default: begin
        newValue       = oldValue;
        writeRequested = 1'b0;
      end
    endcase
  end

  assign csrReadData    = oldValue;
  assign csrIllegal     = csrValid & (~mapped | ((csrAddress[11:10] == 2'b11) & writeRequested));
  assign csrWrite       = csrValid & ~csrIllegal & writeRequested & ~trapTaken & ~mretSignal;
  assign mretTaken      = mretSignal & ~trapTaken;
  assign redirectEvent  = trapTaken | mretSignal;
  assign redirectTarget = trapTaken ? {mtvecBase, 2'b00} : {mepcBase, 2'b00};
  assign mstatusMIE     = mie;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mie       <= 1'b0;
      mpie      <= 1'b0;
      mtvecBase <= RESET_MTVEC[31:2];
      mscratch  <= '0;
      mepcBase  <= '0;
      mcause    <= '0;
      mtval     <= '0;
    end else if (trapTaken) begin
      mepcBase <= trapPC[31:2];
      mcause   <= {28'b0, trapCause};
      mtval    <= trapValue;
      mpie     <= mie;
      mie      <= 1'b0;
    end else if (mretTaken) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csrWrite) begin
      case (csrAddress)
        CSR_MSTATUS: begin
          mie  <= newValue[MSTATUS_MIE_BIT];
          mpie <= newValue[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    mtvecBase <= newValue[31:2];
        CSR_MSCRATCH: mscratch  <= newValue;
        CSR_MEPC:     mepcBase  <= newValue[31:2];
        CSR_MCAUSE:   mcause    <= newValue;
        CSR_MTVAL:    mtval     <= newValue;
        default: ;
      endcase
    end
  end

  csr_counter64 cycleCounter (
    .clock     (clock),
    .reset     (reset),
    .incEnable (1'b1),
    .writeLo   (csrWrite && csrAddress == CSR_MCYCLE),
    .writeHi   (csrWrite && csrAddress == CSR_MCYCLEH),
    .writeData (newValue),
    .count     (mcycle)
  );

  csr_counter64 instretCounter (
    .clock     (clock),
    .reset     (reset),
    .incEnable (retireValid),
    .writeLo   (csrWrite && csrAddress == CSR_MINSTRET),
    .writeHi   (csrWrite && csrAddress == CSR_MINSTRETH),
    .writeData (newValue),
    .count     (minstret)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= REDIRECT_IDLE;
    else        state <= nextState;
  end

  // A fresh event always wins, even when fetch accepts the old target this cycle.
  always_comb begin
    nextState = state;
    case (state)
      REDIRECT_IDLE:    if (redirectEvent) nextState = REDIRECT_PENDING;
      REDIRECT_PENDING: if (!redirectEvent && redirectReady) nextState = REDIRECT_IDLE;
      default:          nextState = REDIRECT_IDLE;
    endcase
  end

  always_comb begin
    redirectValid = (state == REDIRECT_PENDING);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             redirectPC <= '0;
    else if (redirectEvent) redirectPC <= redirectTarget;
  end

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - self-checking bench for trap_csr_unit
module tb_trap_csr_unit;
  import trap_csr_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        trapTaken = 1'b0;
  logic [3:0]  trapCause = '0;
  logic [31:0] trapValue = '0;
  logic [31:0] trapPC = '0;
  logic        mretSignal = 1'b0;
  logic        retireValid = 1'b0;
  logic        csrValid = 1'b0;
  logic [1:0]  csrOp = '0;
  logic [11:0] csrAddress = '0;
  logic [31:0] csrWriteData = '0;
  logic [31:0] csrReadData;
  logic        csrIllegal;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        redirectReady = 1'b0;
  logic        mstatusMIE;

  int checks = 0;
  int errors = 0;
  logic [31:0] redirQ[$];
  logic [31:0] readQ[$];
  logic [31:0] expected;

  trap_csr_unit #(.RESET_MTVEC(32'h100)) dut (
    .clock(clock), .reset(reset), .trapTaken(trapTaken), .trapCause(trapCause),
    .trapValue(trapValue), .trapPC(trapPC), .mretSignal(mretSignal),
    .retireValid(retireValid), .csrValid(csrValid), .csrOp(csrOp),
    .csrAddress(csrAddress), .csrWriteData(csrWriteData), .csrReadData(csrReadData),
    .csrIllegal(csrIllegal), .redirectValid(redirectValid), .redirectPC(redirectPC),
    .redirectReady(redirectReady), .mstatusMIE(mstatusMIE)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs;
    trapTaken = 1'b0; mretSignal = 1'b0; retireValid = 1'b0;
    csrValid = 1'b0; csrOp = 2'b00; csrAddress = '0; csrWriteData = '0;
  endtask

  task automatic setCsr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    csrValid = 1'b1; csrOp = op; csrAddress = addr; csrWriteData = data;
    #1;
  endtask

  task automatic readCsr(input logic [11:0] addr);
    setCsr(CSR_RS, addr, 32'h0);
  endtask

  task automatic test_reset;
    logic [11:0] addrs [5];
    addrs = '{CSR_MSTATUS, CSR_MTVEC, CSR_MISA, CSR_MHARTID, CSR_INSTRET};
    readQ.push_back(32'h0000_1800); readQ.push_back(32'h100);
    readQ.push_back(32'h4000_0100); readQ.push_back(32'h0); readQ.push_back(32'h0);
    idleInputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (redirectValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", redirectValid); end
    checks++; if (redirectPC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", redirectPC); end
    checks++; if (mstatusMIE !== 1'b0) begin errors++; $display("FAIL reset_mie got %0b want 0", mstatusMIE); end
    reset = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      readCsr(addrs[i]);
      expected = readQ.pop_front();
      checks++;
      if (csrReadData !== expected) begin
        errors++; $display("FAIL reset_csr_%h got %h want %h", addrs[i], csrReadData, expected);
      end
    end
    idleInputs();
  endtask

  task automatic test_trap;
    logic [11:0] addrs [4];
    addrs = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    redirectReady = 1'b0;
    trapTaken = 1'b1; trapCause = 4'd2; trapValue = 32'hDEAD; trapPC = 32'h40;
    redirQ.push_back(32'h100);
    readCsr(CSR_MEPC);
    checks++; if (csrReadData !== 32'h0) begin errors++; $display("FAIL trap_preread got %h want 0", csrReadData); end
    tick();
    idleInputs();
    readQ.push_back(32'h40); readQ.push_back(32'h2); readQ.push_back(32'hDEAD); readQ.push_back(32'h1800);
    checks++; if (redirectValid !== 1'b1) begin errors++; $display("FAIL trap_valid got %0b want 1", redirectValid); end
    checks++; if (redirectPC !== redirQ[0]) begin errors++; $display("FAIL trap_pc got %h want %h", redirectPC, redirQ[0]); end
    for (int i = 0; i < 4; i++) begin
      readCsr(addrs[i]);
      expected = readQ.pop_front();
      checks++;
      if (csrReadData !== expected) begin
        errors++; $display("FAIL trap_csr_%h got %h want %h", addrs[i], csrReadData, expected);
      end
    end
    checks++; if (mstatusMIE !== 1'b0) begin errors++; $display("FAIL trap_mie got %0b want 0", mstatusMIE); end
    idleInputs();
    redirectReady = 1'b1;
    void'(redirQ.pop_front());
    tick();
    checks++; if (redirectValid !== 1'b0) begin errors++; $display("FAIL trap_accept got %0b want 0", redirectValid); end
    redirectReady = 1'b0;
  endtask

  task automatic test_mret;
    setCsr(CSR_RS, CSR_MSTATUS, 32'h8);
    tick(); idleInputs();
    checks++; if (mstatusMIE !== 1'b1) begin errors++; $display("FAIL mret_setmie got %0b want 1", mstatusMIE); end
    redirectReady = 1'b1;
    trapTaken = 1'b1; trapCause = 4'd3; trapValue = 32'h0; trapPC = 32'h86;
    redirQ.push_back(32'h100);
    tick();
    trapTaken = 1'b0;
    checks++; if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
      errors++; $display("FAIL mret_trap_redirect got %0b/%h want 1/%h", redirectValid, redirectPC, redirQ[0]);
    end
    void'(redirQ.pop_front());
    readCsr(CSR_MSTATUS);
    checks++; if (csrReadData !== 32'h1880) begin errors++; $display("FAIL mret_trap_mstatus got %h want 00001880", csrReadData); end
    readCsr(CSR_MEPC);
    checks++; if (csrReadData !== 32'h84) begin errors++; $display("FAIL mret_mepc got %h want 00000084", csrReadData); end
    idleInputs();
    tick();
    checks++; if (redirectValid !== 1'b0) begin errors++; $display("FAIL mret_idle got %0b want 0", redirectValid); end
    mretSignal = 1'b1;
    redirQ.push_back(32'h84);
    tick();
    mretSignal = 1'b0;
    checks++; if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
      errors++; $display("FAIL mret_redirect got %0b/%h want 1/%h", redirectValid, redirectPC, redirQ[0]);
    end
    void'(redirQ.pop_front());
    readCsr(CSR_MSTATUS);
    checks++; if (csrReadData !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h want 00001888", csrReadData); end
    checks++; if (mstatusMIE !== 1'b1) begin errors++; $display("FAIL mret_mie got %0b want 1", mstatusMIE); end
    idleInputs();
    tick();
    redirectReady = 1'b0;
  endtask

  task automatic test_pending_hold;
    redirectReady = 1'b0;
    trapTaken = 1'b1; trapCause = 4'd1; trapValue = 32'h7; trapPC = 32'h10;
    redirQ.push_back(32'h100);
    tick();
    trapTaken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
        errors++; $display("FAIL hold_cycle%0d got %0b/%h want 1/%h", i, redirectValid, redirectPC, redirQ[0]);
      end
      tick();
    end
    setCsr(CSR_RW, CSR_MTVEC, 32'h201);
    tick(); idleInputs();
    readCsr(CSR_MTVEC);
    checks++; if (csrReadData !== 32'h200) begin errors++; $display("FAIL hold_mtvec got %h want 00000200", csrReadData); end
    idleInputs();
    redirectReady = 1'b1;
    trapTaken = 1'b1;
    checks++; if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
      errors++; $display("FAIL hold_before_retrap got %0b/%h want 1/%h", redirectValid, redirectPC, redirQ[0]);
    end
    void'(redirQ.pop_front());
    redirQ.push_back(32'h200);
    tick();
    trapTaken = 1'b0; redirectReady = 1'b0;
    checks++; if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
      errors++; $display("FAIL hold_retrap got %0b/%h want 1/%h", redirectValid, redirectPC, redirQ[0]);
    end
    redirectReady = 1'b1;
    void'(redirQ.pop_front());
    tick();
    checks++; if (redirectValid !== 1'b0) begin errors++; $display("FAIL hold_drain got %0b want 0", redirectValid); end
    redirectReady = 1'b0;
  endtask

  task automatic test_counters;
    setCsr(CSR_RW, CSR_MCYCLE, 32'h1000);
    tick(); idleInputs();
    setCsr(CSR_RW, CSR_CYCLE, 32'h5);
    checks++; if (csrIllegal !== 1'b1) begin errors++; $display("FAIL cnt_ro_illegal got %0b want 1", csrIllegal); end
    checks++; if (csrReadData !== 32'h1000) begin errors++; $display("FAIL cnt_write_wins got %h want 00001000", csrReadData); end
    tick(); idleInputs();
    readCsr(CSR_CYCLE);
    checks++; if (csrIllegal !== 1'b0) begin errors++; $display("FAIL cnt_ro_read_legal got %0b want 0", csrIllegal); end
    checks++; if (csrReadData !== 32'h1001) begin errors++; $display("FAIL cnt_unchanged got %h want 00001001", csrReadData); end
    setCsr(CSR_RW, 12'h7FF, 32'h1);
    checks++; if (csrIllegal !== 1'b1 || csrReadData !== 32'h0) begin
      errors++; $display("FAIL cnt_unmapped got %0b/%h want 1/00000000", csrIllegal, csrReadData);
    end
    setCsr(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    tick();
    setCsr(CSR_RW, CSR_MCYCLEH, 32'h0);
    tick(); idleInputs();
    readCsr(CSR_MCYCLE);
    checks++; if (csrReadData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_prewrap_lo got %h want ffffffff", csrReadData); end
    tick();
    readCsr(CSR_MCYCLE);
    checks++; if (csrReadData !== 32'h0) begin errors++; $display("FAIL cnt_wrap_lo got %h want 0", csrReadData); end
    readCsr(CSR_MCYCLEH);
    checks++; if (csrReadData !== 32'h1) begin errors++; $display("FAIL cnt_wrap_hi got %h want 1", csrReadData); end
    idleInputs();
    retireValid = 1'b1;
    setCsr(CSR_RW, CSR_MINSTRET, 32'd10);
    tick();
    idleInputs(); retireValid = 1'b1;
    repeat (2) tick();
    retireValid = 1'b0;
    readCsr(CSR_INSTRET);
    checks++; if (csrReadData !== 32'd12) begin errors++; $display("FAIL cnt_instret got %0d want 12", csrReadData); end
    idleInputs();
  endtask

  task automatic test_priority;
    setCsr(CSR_RS, CSR_MSTATUS, 32'h8);
    tick(); idleInputs();
    redirectReady = 1'b1;
    trapTaken = 1'b1; mretSignal = 1'b1; trapPC = 32'h2C; trapCause = 4'd11;
    setCsr(CSR_RW, CSR_MSCRATCH, 32'h55);
    redirQ.push_back(32'h200);
    tick(); idleInputs();
    checks++; if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
      errors++; $display("FAIL prio_redirect got %0b/%h want 1/%h", redirectValid, redirectPC, redirQ[0]);
    end
    void'(redirQ.pop_front());
    readCsr(CSR_MSCRATCH);
    checks++; if (csrReadData !== 32'h0) begin errors++; $display("FAIL prio_mscratch got %h want 0", csrReadData); end
    checks++; if (mstatusMIE !== 1'b0) begin errors++; $display("FAIL prio_mie got %0b want 0", mstatusMIE); end
    idleInputs();
    tick();
    redirectReady = 1'b0;
  endtask

  task automatic test_back_to_back;
    redirectReady = 1'b1;
    trapTaken = 1'b1; trapPC = 32'h300;
    redirQ.push_back(32'h200);
    tick();
    trapTaken = 1'b0; mretSignal = 1'b1;
    checks++; if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
      errors++; $display("FAIL b2b_first got %0b/%h want 1/%h", redirectValid, redirectPC, redirQ[0]);
    end
    void'(redirQ.pop_front());
    redirQ.push_back(32'h300);
    tick();
    mretSignal = 1'b0;
    checks++; if (redirectValid !== 1'b1 || redirectPC !== redirQ[0]) begin
      errors++; $display("FAIL b2b_second got %0b/%h want 1/%h", redirectValid, redirectPC, redirQ[0]);
    end
    void'(redirQ.pop_front());
    tick();
    checks++; if (redirectValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", redirectValid); end
    redirectReady = 1'b0;
    trapTaken = 1'b1;
    tick();
    trapTaken = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (redirectValid !== 1'b0 || redirectPC !== 32'h0) begin
      errors++; $display("FAIL b2b_reset_drop got %0b/%h want 0/00000000", redirectValid, redirectPC);
    end
    redirQ.delete();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_trap();
    test_mret();
    test_pending_hold();
    test_counters();
    test_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
Machine-mode CSR file and trap sequencer sitting directly downstream of the hazard/trap-detection logic. Consumes the trap-taken strobe, cause and tval it produces, plus the mret strobe. Updates mepc/mcause/mtval/mstatus and holds a registered fetch-redirect request until fetch accepts it. Also services CSR instructions from the writeback stage and maintains the cycle and instret counters.

Parameters:
RESET_MTVEC, 32'h0000_0000, mtvec reset value; trap target after reset.
MISA_VALUE, 32'h4000_0100, read-only misa (RV32I).
HART_ID, 32'd0, read-only mhartid.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
trapTaken  in  1  trap commit strobe (hazard controlReset)
trapCause  in  4  exception code (hazard mcause)
trapValue  in  32  faulting address/value (hazard mtval)
trapPC  in  32  PC of the trapping instruction
mretSignal  in  1  mret committing
retireValid  in  1  one instruction retired this cycle
csrValid  in  1  CSR instruction at writeback
csrOp  in  2  csrOp_ encoding: RW / RS / RC
csrAddress  in  12  CSR address
csrWriteData  in  32  rs1 value or zero-extended uimm
csrReadData  out  32  old CSR value (combinational)
csrIllegal  out  1  unknown address or write to read-only CSR (combinational)
redirectValid  out  1  redirect request pending
redirectPC  out  32  redirect target
redirectReady  in  1  fetch accepts redirect
mstatusMIE  out  1  current MIE bit

Behaviour:
- Reset (async, reset=0): mstatus MIE=0, MPIE=0, MPP=2'b11 (fixed); mtvec=RESET_MTVEC with bits[1:0]=0; mepc, mcause, mtval, mscratch, mcycle, minstret = 0; redirectValid=0, redirectPC=0; FSM=IDLE. Reset mid-redirect drops the request.
- CSR map: 0x300 mstatus (only MIE[3], MPIE[7] writable; MPP reads 11), 0x301 misa RO, 0x305 mtvec (direct only; bits[1:0] write as 0), 0x340 mscratch, 0x341 mepc (bits[1:0] forced 0), 0x342 mcause ({28'b0, cause}, all 32 bits writable), 0x343 mtval, 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi, 0xC00/0xC80/0xC02/0xC82 RO aliases, 0xF14 mhartid RO.
- CSR op: new = RW: wdata; RS: old|wdata; RC: old&~wdata. Write occurs when op==RW, or when RS/RC and wdata!=0. csrIllegal = csrValid & (address unmapped | (address[11:10]==2'b11 & write would occur)). No state changes on illegal. csrReadData returns 0 for unmapped addresses.
- Counters: 64-bit, mcycle += 1 every cycle; minstret += 1 on retireValid. A CSR write to a counter half in the same cycle wins over the increment for the whole 64-bit counter (written half takes wdata, other half holds). Wrap from all-ones to 0 silently.
- Trap entry (trapTaken): mepc<=trapPC&~3, mcause<={28'b0,trapCause}, mtval<=trapValue, MPIE<=MIE, MIE<=0; target={mtvec[31:2],2'b00}.
- mret (mretSignal & !trapTaken): MIE<=MPIE, MPIE<=1; target=mepc.
- Priority in one cycle: trapTaken > mretSignal > CSR write. A coincident CSR write is discarded. retireValid still counts.
- Redirect FSM: IDLE -> PENDING on trap or mret; redirectPC registered (visible the cycle after the event), redirectValid=1 in PENDING. PENDING -> IDLE on redirectReady; a transfer completes when redirectValid & redirectReady. A new trap/mret while PENDING overwrites redirectPC and stays PENDING, including when it coincides with redirectReady. Latency event->redirectValid: 1 cycle.
- CSR reads in the same cycle as a trap return the pre-trap value.

Decomposition:
- Shared package: csrOp_ enum (CSR_RW=2'b01, CSR_RS=2'b10, CSR_RC=2'b11), CSR address localparams, redirect FSM state enum, mstatus bit-position constants.
- Sub-module csr_counter64: 64-bit counter with increment enable and per-half write.
- Everything else stays in the top module.

Test Plan:
- Reset release with RESET_MTVEC=0x100; trapTaken, cause=2, value=0xDEAD, trapPC=0x40 -> next cycle redirectValid=1, redirectPC=0x100; mepc=0x40, mcause=2, mtval=0xDEAD, MIE=0.
- Write mstatus RS 0x8 (MIE=1), then trap, then mret with redirectReady held 1 -> first redirect 0x100; after mret redirect=mepc, MIE=1, MPIE=1.
- Hold redirectReady=0 for 5 cycles after a trap -> redirectValid stays 1 and redirectPC stays stable. Second trap (mtvec rewritten to 0x200) while pending -> redirectPC=0x200.
- csrValid RW to 0xC00 -> csrIllegal=1 and counter unchanged. RS 0xC00 with wdata=0 -> legal, returns low mcycle. Address 0x7FF -> csrIllegal=1, readData=0.
- Write mcycle=0xFFFF_FFFF via 0xB00, mcycleh=0 -> after 1 cycle mcycle=0x1_0000_0000. Same-cycle write vs increment -> write value wins.
- trapTaken with simultaneous mretSignal and RW mscratch=0x55 -> trap target used, mscratch unchanged, MIE=0.
